// File: rtl/pad_gpio_ctrl_if.sv
// Register bus and pad-cell bundle for pad_gpio_ctrl.
// Latency: none; plain wiring between the controller and its host and pads.
// Backpressure: none; the register port is accepted every cycle.
//
// Signals:
//   wr_en/wr_addr/wr_data : register write strobe, address and data
//   rd_addr/rd_data       : register read address and registered read data
//   pad_din/pad_oen       : drive value and active-low output enable to each pad
//   pad_dout              : asynchronous value sampled from each pad
//   irq                   : level interrupt
// master = host/pad side, slave = controller side.
interface pad_gpio_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             wr_en;
    logic [2:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [2:0]       rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] pad_din;
    logic [WIDTH-1:0] pad_oen;
    logic [WIDTH-1:0] pad_dout;
    logic             irq;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, pad_dout,
        input  rd_data, pad_din, pad_oen, irq
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, pad_dout,
        output rd_data, pad_din, pad_oen, irq
    );
endinterface

// File: rtl/pad_gpio_ctrl.sv
// GPIO controller for bidirectional pad cells with turnaround guard and edge interrupt.
// Latency: reads 1 cycle; OUT->pad_din 1 cycle; DIR enable->OEN low TURN_CYC+1 cycles; pad->IRQ_STAT 2 edges.
// Backpressure: none; every register access is accepted in the cycle it is presented.
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : pad_gpio_ctrl_if.slave (register write/read port, pad DIN/OEN/DOUT, irq)
//
// Register map: 0 OUT (RW), 1 DIR (RW, 1 = output requested), 2 IN (RO),
// 3 IRQ_EN (RW), 4 IRQ_STAT (W1C), 5-7 read as zero.
module pad_gpio_ctrl #(
    parameter int               WIDTH       = 4,
    parameter int               TURN_CYC    = 4,
    parameter logic [WIDTH-1:0] PAD_RST_VAL = {WIDTH{1'b1}}
) (
    input  logic           clk,
    input  logic           rst,
    pad_gpio_ctrl_if.slave bus
);

    localparam logic [2:0] A_OUT  = 3'd0;
    localparam logic [2:0] A_DIR  = 3'd1;
    localparam logic [2:0] A_IN   = 3'd2;
    localparam logic [2:0] A_IEN  = 3'd3;
    localparam logic [2:0] A_STAT = 3'd4;

    // The counter is loaded with TURN_CYC and the enable is applied on the edge
    // that observes zero, so OEN first goes low TURN_CYC+1 edges after the DIR
    // write. That leaves TURN_CYC full cycles in which the pad being released
    // has already stopped driving and the new one has not yet started.
    localparam logic [3:0] TURN_LD = 4'(TURN_CYC);

    typedef enum logic {
        IDLE = 1'b0,
        TURN = 1'b1
    } state_t;

    // Programmer-visible registers
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] ien_q;
    logic [WIDTH-1:0] stat_q;
    logic [WIDTH-1:0] stat_d;

    // Pad-side pipeline
    logic [WIDTH-1:0] din_q;
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] prev_q;

    // Read port
    logic [WIDTH-1:0] rd_q;
    logic [WIDTH-1:0] rd_d;

    // Turnaround sequencer
    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] act_q;
    logic [WIDTH-1:0] pend_q;

    // Decoded write strobes and derived masks
    logic             wr_out;
    logic             wr_dir;
    logic             wr_ien;
    logic             wr_stat;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] new_req;
    logic [WIDTH-1:0] pend_mask;
    logic [WIDTH-1:0] edge_det;

    always_comb begin
        wr_out  = bus.wr_en && (bus.wr_addr == A_OUT);
        wr_dir  = bus.wr_en && (bus.wr_addr == A_DIR);
        wr_ien  = bus.wr_en && (bus.wr_addr == A_IEN);
        wr_stat = bus.wr_en && (bus.wr_addr == A_STAT);

        w1c     = wr_stat ? bus.wr_data : '0;

        // Bits asked to drive that are not driving yet; already-active bits
        // that stay requested keep driving without a new guard interval.
        new_req = bus.wr_data & ~act_q;

        // Pins that are driving or waiting to drive would see their own
        // (or the partner pad's) transition, so they never raise an edge.
        pend_mask = (state_q == TURN) ? pend_q : '0;
        edge_det  = (sync2_q ^ prev_q) & ~act_q & ~pend_mask;

        // A new edge wins over a simultaneous write-one-to-clear.
        stat_d = (stat_q & ~w1c) | edge_det;
    end

    always_comb begin
        rd_d = '0;
        case (bus.rd_addr)
            A_OUT:   rd_d = out_q;
            A_DIR:   rd_d = dir_q;
            A_IN:    rd_d = sync2_q;
            A_IEN:   rd_d = ien_q;
            A_STAT:  rd_d = stat_q;
            default: rd_d = '0;
        endcase
    end

    // Registers, read pipeline and input synchroniser
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            dir_q   <= '0;
            ien_q   <= '0;
            stat_q  <= '0;
            din_q   <= '0;
            rd_q    <= '0;
            // Start from the pull level so release from reset is not an edge.
            sync1_q <= PAD_RST_VAL;
            sync2_q <= PAD_RST_VAL;
            prev_q  <= PAD_RST_VAL;
        end else begin
            if (wr_out) begin
                out_q <= bus.wr_data;
            end
            if (wr_dir) begin
                dir_q <= bus.wr_data;
            end
            if (wr_ien) begin
                ien_q <= bus.wr_data;
            end
            stat_q  <= stat_d;
            din_q   <= out_q;
            rd_q    <= rd_d;
            sync1_q <= bus.pad_dout;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Turnaround sequencer. Releases take effect on the DIR write edge; new
    // drive requests wait out the guard interval. Any DIR write during the
    // guard recomputes the pending set and restarts the count, so a pin whose
    // request is withdrawn before expiry never drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            act_q   <= '0;
            pend_q  <= '0;
        end else if (wr_dir) begin
            act_q <= act_q & bus.wr_data;
            if (new_req != '0) begin
                state_q <= TURN;
                cnt_q   <= TURN_LD;
                pend_q  <= new_req;
            end else begin
                state_q <= IDLE;
                cnt_q   <= '0;
                pend_q  <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    pend_q <= '0;
                end
                TURN: begin
                    if (cnt_q == 4'd0) begin
                        act_q   <= act_q | (pend_q & dir_q);
                        pend_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    pend_q  <= '0;
                end
            endcase
        end
    end

    assign bus.rd_data = rd_q;
    assign bus.pad_din = din_q;
    assign bus.pad_oen = ~act_q;
    assign bus.irq     = |(stat_q & ien_q);

endmodule
